// File: rtl/hamming_secded_write_encoder.sv
// -----------------------------------------------------------------------------
// hamming_secded_write_encoder
//
// Purpose:
//   Encodes each accepted data byte into a 13-bit extended Hamming (SEC-DED)
//   codeword and buffers up to two encoded words for a downstream sink using
//   valid/ready handshakes on both sides. A one-shot error-injection mask can
//   be armed and is XORed into the next accepted codeword before buffering.
//   A wrapping counter reports how many output handshakes have completed.
//
// Ports:
//   clk          in   1      single clock, rising-edge active
//   rst          in   1      asynchronous, active-high reset
//   in_valid     in   1      source presents in_data
//   in_ready     out  1      block can accept a word this cycle (registered)
//   in_data      in   8      data byte to protect
//   out_valid    out  1      out_code holds a valid codeword (registered)
//   out_ready    in   1      sink accepts out_code this cycle
//   out_code     out  13     oldest buffered SEC-DED codeword
//   inj_arm      in   1      pulse that captures inj_mask
//   inj_mask     in   13     bit-flip mask applied to one future codeword
//   inj_pending  out  1      an armed mask waits for the next accepted word
//   word_count   out  CNT_W  number of completed output handshakes (wraps)
//
// Codeword layout: bit0 = overall even parity, bits 1/2/4/8 = p1/p2/p4/p8,
// data d0..d7 at bit positions 3,5,6,7,9,10,11,12.
// -----------------------------------------------------------------------------
module hamming_secded_write_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [12:0]      out_code,
    input  logic             inj_arm,
    input  logic [12:0]      inj_mask,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    buf_state_t        r_state;
    buf_state_t        w_state_nxt;

    // r_head is always the oldest word (drives out_code); r_tail the younger.
    logic [12:0]       r_head;
    logic [12:0]       r_tail;
    logic [12:0]       w_head_nxt;
    logic [12:0]       w_tail_nxt;

    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_inj_pending;
    logic [12:0]       r_mask;
    logic [CNT_W-1:0]  r_word_count;

    logic              w_accept;
    logic              w_deliver;
    logic [12:0]       w_enc;
    logic [12:0]       w_store;

    // Extended Hamming(13,8) encoder: data placement, four parity bits, then
    // the overall parity bit that makes the full word even.
    function automatic logic [12:0] secded_encode(input logic [7:0] d);
        logic [12:0] c;
        c      = 13'd0;
        c[3]   = d[0];
        c[5]   = d[1];
        c[6]   = d[2];
        c[7]   = d[3];
        c[9]   = d[4];
        c[10]  = d[5];
        c[11]  = d[6];
        c[12]  = d[7];
        c[1]   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        c[2]   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        c[4]   = d[1] ^ d[2] ^ d[3] ^ d[7];
        c[8]   = d[4] ^ d[5] ^ d[6] ^ d[7];
        c[0]   = ^c[12:1];
        return c;
    endfunction

    assign w_accept  = in_valid & r_in_ready;
    assign w_deliver = r_out_valid & out_ready;
    assign w_enc     = secded_encode(in_data);

    // The pending mask (old value, even if re-armed this cycle) corrupts the
    // word being accepted; an idle shadow register leaves the word untouched.
    always_comb begin
        w_store = w_enc;
        if (r_inj_pending) begin
            w_store = w_enc ^ r_mask;
        end else begin
            w_store = w_enc;
        end
    end

    // Buffer next-state and storage update for the three occupancy states.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_head_nxt  = w_store;
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_accept && w_deliver) begin
                    w_head_nxt  = w_store;
                    w_state_nxt = ST_ONE;
                end else if (w_accept) begin
                    w_tail_nxt  = w_store;
                    w_state_nxt = ST_FULL;
                end else if (w_deliver) begin
                    w_state_nxt = ST_EMPTY;
                end else begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low while full, so only a delivery can occur.
                if (w_deliver) begin
                    w_head_nxt  = r_tail;
                    w_state_nxt = ST_ONE;
                end else begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Buffer state, storage and the handshake flags derived from next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_head      <= 13'd0;
            r_tail      <= 13'd0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_head      <= w_head_nxt;
            r_tail      <= w_tail_nxt;
            r_in_ready  <= (w_state_nxt != ST_FULL);
            r_out_valid <= (w_state_nxt != ST_EMPTY);
        end
    end

    // Injection shadow mask: arming wins over consumption, so arm+accept
    // keeps the flag set with the new mask loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask        <= 13'd0;
            r_inj_pending <= 1'b0;
        end else if (inj_arm) begin
            r_mask        <= inj_mask;
            r_inj_pending <= 1'b1;
        end else if (w_accept) begin
            r_inj_pending <= 1'b0;
        end else begin
            r_inj_pending <= r_inj_pending;
        end
    end

    // Output handshake counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_count <= {CNT_W{1'b0}};
        end else if (w_deliver) begin
            r_word_count <= r_word_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_word_count <= r_word_count;
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_code    = r_head;
    assign inj_pending = r_inj_pending;
    assign word_count  = r_word_count;

endmodule

// File: tb/tb_hamming_secded_write_encoder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hamming_secded_write_encoder. A behavioural model
// (queue of expected codewords, occupancy-derived ready, injection state) is
// compared against the DUT every falling edge; directed tests additionally pin
// literal codewords taken from the delivered-word log.
// -----------------------------------------------------------------------------
module tb_hamming_secded_write_encoder;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [12:0]      out_code;
    logic             inj_arm;
    logic [12:0]      inj_mask;
    logic             inj_pending;
    logic [CNT_W-1:0] word_count;

    int checks;
    int errors;

    hamming_secded_write_encoder #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_code    (out_code),
        .inj_arm     (inj_arm),
        .inj_mask    (inj_mask),
        .inj_pending (inj_pending),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Generic Hamming rule: data fills non-power-of-two positions in order,
    // parity bit p covers every position whose index has bit p set.
    function automatic logic [12:0] model_enc(input logic [7:0] d);
        logic [12:0] c;
        int k;
        c = 13'd0;
        k = 0;
        for (int pos = 1; pos < 13; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int p = 1; p < 13; p = p * 2) begin
            for (int pos = 1; pos < 13; pos++) begin
                if (((pos & p) != 0) && (pos != p)) c[p] = c[p] ^ c[pos];
            end
        end
        c[0] = ^c[12:1];
        return c;
    endfunction

    // Reference SEC-DED decoder: syndrome is XOR of set positions.
    task automatic secded_dec(input logic [12:0] c, output logic [3:0] syn,
                              output logic par, output logic [7:0] d);
        logic [12:0] x;
        int k;
        x   = c;
        syn = 4'd0;
        for (int pos = 1; pos < 13; pos++) begin
            if (x[pos]) syn = syn ^ 4'(pos);
        end
        par = ^x;
        if (par) begin
            if (syn == 4'd0) x[0] = ~x[0];
            else if (syn < 4'd13) x[syn] = ~x[syn];
        end
        k = 0;
        d = 8'd0;
        for (int pos = 1; pos < 13; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = x[pos];
                k++;
            end
        end
    endtask

    typedef struct {
        logic [12:0] code;
        logic [7:0]  data;
        int          flips;
    } ent_t;

    ent_t             mq[$];
    logic [12:0]      log_codes[$];
    logic             m_in_ready;
    logic             m_pend;
    logic [12:0]      m_mask;
    logic [CNT_W-1:0] m_cnt;

    // Compare-then-advance model, evaluated on the falling edge when inputs are stable.
    always @(negedge clk) begin
        logic acc;
        logic del;
        ent_t e;
        logic [12:0] applied;
        logic [3:0] syn;
        logic par;
        logic [7:0] dd;
        if (rst) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_inj_pending", inj_pending, 0);
            chk("rst_word_count", word_count, 0);
            chk("rst_out_code", out_code, 0);
            mq.delete();
            m_in_ready = 1'b0;
            m_pend     = 1'b0;
            m_mask     = 13'd0;
            m_cnt      = '0;
        end else begin
            chk("out_valid", out_valid, mq.size() > 0);
            chk("in_ready", in_ready, m_in_ready);
            chk("inj_pending", inj_pending, m_pend);
            chk("word_count", word_count, m_cnt);
            if (mq.size() > 0) chk("out_code", out_code, mq[0].code);
            acc = in_valid && m_in_ready;
            del = (mq.size() > 0) && out_ready;
            if (del) begin
                e = mq.pop_front();
                log_codes.push_back(out_code);
                m_cnt = m_cnt + 1'b1;
                secded_dec(out_code, syn, par, dd);
                if (e.flips == 0) begin
                    chk("clean_parity", par, 0);
                    chk("clean_syndrome", syn, 0);
                    chk("clean_decode", dd, e.data);
                end else if (e.flips == 1) begin
                    chk("sec_flagged", par, 1);
                    chk("sec_corrected", dd, e.data);
                end
            end
            if (acc) begin
                applied = m_pend ? m_mask : 13'd0;
                e.code  = model_enc(in_data) ^ applied;
                e.data  = in_data;
                e.flips = $countones(applied);
                mq.push_back(e);
            end
            if (inj_arm) begin
                m_pend = 1'b1;
                m_mask = inj_mask;
            end else if (acc) begin
                m_pend = 1'b0;
            end
            m_in_ready = (mq.size() < 2);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic arm, input logic [12:0] m);
        int n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        inj_arm  = arm;
        inj_mask = m;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        inj_arm  = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic arm_only(input logic [12:0] m);
        inj_arm  = 1'b1;
        inj_mask = m;
        @(posedge clk);
        #1;
        inj_arm  = 1'b0;
        inj_mask = 13'h1FFF;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    logic rnd_done;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        inj_arm   = 1'b0;
        inj_mask  = 13'h0;
        rnd_done  = 1'b0;

        // Literal pins of the model encoder.
        chk("pin_enc_00", model_enc(8'h00), 13'h0000);
        chk("pin_enc_ff", model_enc(8'hFF), 13'h1EEE);
        chk("pin_enc_01", model_enc(8'h01), 13'h000F);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 chk("first_cycle_in_ready", in_ready, 1);

        // Three words with the sink always ready.
        out_ready = 1'b1;
        log_codes.delete();
        send(8'h00, 1'b0, 13'h0);
        send(8'hFF, 1'b0, 13'h0);
        send(8'h01, 1'b0, 13'h0);
        drain();
        chk("basic_n", log_codes.size(), 3);
        if (log_codes.size() == 3) begin
            chk("basic_w0", log_codes[0], 13'h0000);
            chk("basic_w1", log_codes[1], 13'h1EEE);
            chk("basic_w2", log_codes[2], 13'h000F);
        end
        chk("basic_count", word_count, 3);

        // Stalled sink: third word must wait until the sink drains.
        out_ready = 1'b0;
        log_codes.delete();
        fork
            begin
                send(8'h11, 1'b0, 13'h0);
                send(8'h22, 1'b0, 13'h0);
                send(8'h33, 1'b0, 13'h0);
            end
            begin
                repeat (6) @(posedge clk);
                #1 chk("stall_in_ready", in_ready, 0);
                chk("stall_head", out_code, model_enc(8'h11));
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_n", log_codes.size(), 3);
        if (log_codes.size() == 3) begin
            chk("stall_w0", log_codes[0], model_enc(8'h11));
            chk("stall_w2", log_codes[2], model_enc(8'h33));
        end

        // Single-bit injection then a clean word.
        log_codes.delete();
        arm_only(13'h0008);
        chk("inj_armed", inj_pending, 1);
        send(8'hFF, 1'b0, 13'h0);
        chk("inj_cleared", inj_pending, 0);
        send(8'hFF, 1'b0, 13'h0);
        drain();
        if (log_codes.size() == 2) begin
            chk("inj_w0", log_codes[0], 13'h1EE6);
            chk("inj_w1", log_codes[1], 13'h1EEE);
        end else begin
            chk("inj_n", log_codes.size(), 2);
        end

        // Re-arm coincident with an accept while a mask is pending.
        log_codes.delete();
        arm_only(13'h0001);
        send(8'h00, 1'b1, 13'h0003);
        chk("rearm_pending", inj_pending, 1);
        send(8'h00, 1'b0, 13'h0);
        drain();
        if (log_codes.size() == 2) begin
            chk("rearm_w0", log_codes[0], 13'h0001);
            chk("rearm_w1", log_codes[1], 13'h0003);
        end else begin
            chk("rearm_n", log_codes.size(), 2);
        end

        // Zero mask is consumed without altering the word.
        arm_only(13'h0000);
        send(8'h5A, 1'b0, 13'h0);
        chk("zero_mask_cleared", inj_pending, 0);
        drain();

        // Counter wrap with a 4-bit counter.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(8'(i * 7), 1'b0, 13'h0);
        drain();
        chk("wrap_count", word_count, 1);

        // Reset with a full buffer and a pending injection.
        out_ready = 1'b0;
        send(8'hC3, 1'b0, 13'h0);
        send(8'h3C, 1'b0, 13'h0);
        arm_only(13'h0100);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_pending", inj_pending, 0);
        chk("midrst_out_code", out_code, 0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("midrst_count", word_count, 0);
        chk("midrst_nothing_out", out_valid, 0);

        // Random data, toggling sink, single-bit masks at every position.
        fork
            begin
                for (int k = 0; k < 13; k++) begin
                    arm_only(13'(1 << k));
                    send(8'($urandom_range(0, 255)), 1'b0, 13'h0);
                    send(8'($urandom_range(0, 255)), 1'b0, 13'h0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hamming_secded_write_encoder.md
HAMMING_SECDED_WRITE_ENCODER -- requirements
Module: hamming_secded_write_encoder

Interface
REQ-001 Parameter CNT_W, default 16: width of the output-word counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  source presents in_data.
REQ-005 in_ready  output  1  block can accept a word this cycle.
REQ-006 in_data  input  8  data byte to protect.
REQ-007 out_valid  output  1  out_code holds a valid codeword.
REQ-008 out_ready  input  1  sink accepts out_code this cycle.
REQ-009 out_code  output  13  SEC-DED codeword.
REQ-010 inj_arm  input  1  one-cycle pulse that captures inj_mask for error injection.
REQ-011 inj_mask  input  13  bit-flip mask applied to one future codeword.
REQ-012 inj_pending  output  1  an armed mask is waiting for the next accepted word.
REQ-013 word_count  output  CNT_W  number of output handshakes completed.

Function
REQ-014 Input handshake: a word is accepted when in_valid and in_ready are both high at a rising edge. Output handshake: a word is delivered when out_valid and out_ready are both high.
REQ-015 Codeword layout: bit0 = overall parity; bits 1, 2, 4, 8 = p1, p2, p4, p8; data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
REQ-016 Parity bits:
- p1 = d0^d1^d3^d4^d6
- p2 = d0^d2^d3^d5^d6
- p4 = d1^d2^d3^d7
- p8 = d4^d5^d6^d7
- bit0 = XOR of code[12:1], giving even parity over all 13 bits.
REQ-017 Encoding is registered; an accepted word is visible on out_code with out_valid high in the cycle after acceptance (1-cycle latency) when the buffer was empty.
REQ-018 Buffer: 2-entry FIFO of encoded words. Words leave in acceptance order; none is dropped or duplicated.
REQ-019 in_ready is a registered signal: in_ready = 1 when fewer than 2 entries are held after the current edge.
REQ-020 At most one word may enter and one word may leave per cycle.
REQ-021 Simultaneous accept and deliver leaves the occupancy unchanged. With 2 entries held, in_ready is 0, so no accept can occur.
REQ-022 out_valid = 1 whenever occupancy is 1 or more. out_code is the oldest entry and stays stable while out_valid is high and out_ready is low.
REQ-023 Buffer states: EMPTY (0 entries), ONE (1 entry), FULL (2 entries).
- accept only: EMPTY->ONE, ONE->FULL
- deliver only: FULL->ONE, ONE->EMPTY
- accept and deliver: stay in the current state
REQ-024 Injection arming: inj_arm high at an edge loads inj_mask into a shadow register and sets inj_pending. Arming again while pending overwrites the shadow mask.
REQ-025 Injection use: the first word accepted while inj_pending is high is stored as codeword XOR shadow mask, and inj_pending clears at that edge.
REQ-026 If inj_arm and an accept coincide:
- when inj_pending was already high, the accepted word uses the old mask, the new mask is loaded, and inj_pending stays high;
- when inj_pending was low, the accepted word is unmodified and inj_pending sets.
REQ-027 A mask of 0 is legal; the word is stored unmodified and inj_pending still clears.
REQ-028 word_count increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0.
REQ-029 in_data is ignored when in_valid is low. out_ready is ignored when out_valid is low.

Reset
REQ-030 rst asserted immediately forces:
- out_valid = 0, in_ready = 0, inj_pending = 0
- word_count = 0, out_code = 0, buffer EMPTY
- shadow mask = 0
REQ-031 In the first cycle after rst deasserts, in_ready = 1.
REQ-032 Assertion of rst mid-transfer discards all buffered words and any pending injection, with no output handshake completing.

Verification
REQ-033 Reset, then in_data 0x00, 0xFF, 0x01 with out_ready = 1 -> out_code 0x0000, 0x1EEE, 0x000F on consecutive cycles, each one cycle after its accept; word_count = 3.
REQ-034 out_ready = 0 and three back-to-back valid inputs:
- required response: in_ready drops after the second accept, and the third word waits.
- then raise out_ready: all three words appear in order, and out_code is stable while stalled.
REQ-035 inj_arm with inj_mask 0x0008, then in_data 0xFF -> out_code 0x1EE6, inj_pending clears; the following 0xFF gives 0x1EEE.
REQ-036 Same-cycle inj_arm (mask 0x0003) and accept while a 0x0001 mask is pending -> current word XOR 0x0001, next word XOR 0x0003.
REQ-037 CNT_W = 4, 17 output handshakes -> word_count = 1; rst asserted with FULL buffer -> out_valid 0 immediately, nothing delivered.
REQ-038 Random data with out_ready toggling, checked by a reference model:
- every out_code has even 13-bit parity and decodes to its in_data;
- the single-bit mask at each position 0..12 is flagged and corrected by the team's SEC-DED decoder.
